// File: rtl/operand_fetch_stage_if.sv
// Bundle of the operand fetch stage's decode, register-file, bypass and ID/EX signals.
// The slave modport is the stage itself; the master modport is its surrounding pipeline.
interface operand_fetch_stage_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rs1;
    logic [ADDR_WIDTH-1:0] in_rs2;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_reg_write;
    logic                  in_is_load;
    logic [ADDR_WIDTH-1:0] rf_addrA;
    logic [ADDR_WIDTH-1:0] rf_addrB;
    logic [DATA_WIDTH-1:0] rf_dataA;
    logic [DATA_WIDTH-1:0] rf_dataB;
    logic [ADDR_WIDTH-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_is_load;
    logic [DATA_WIDTH-1:0] ex_result;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic                  wb_reg_write;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_opA;
    logic [DATA_WIDTH-1:0] out_opB;
    logic [ADDR_WIDTH-1:0] out_rd;
    logic                  out_reg_write;
    logic                  out_is_load;
    logic [CNT_WIDTH-1:0]  stall_count;

    modport slave (
        input  flush, in_valid, in_rs1, in_rs2, in_rd, in_reg_write, in_is_load,
        input  rf_dataA, rf_dataB,
        input  ex_rd, ex_reg_write, ex_is_load, ex_result,
        input  wb_rd, wb_reg_write, wb_data,
        input  out_ready,
        output in_ready, rf_addrA, rf_addrB,
        output out_valid, out_opA, out_opB, out_rd, out_reg_write, out_is_load,
        output stall_count
    );

    modport master (
        output flush, in_valid, in_rs1, in_rs2, in_rd, in_reg_write, in_is_load,
        output rf_dataA, rf_dataB,
        output ex_rd, ex_reg_write, ex_is_load, ex_result,
        output wb_rd, wb_reg_write, wb_data,
        output out_ready,
        input  in_ready, rf_addrA, rf_addrB,
        input  out_valid, out_opA, out_opB, out_rd, out_reg_write, out_is_load,
        input  stall_count
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch: register-file addressing, EX/WB bypass, load-use stall detection
// and the ID/EX pipeline register with a valid/ready handshake.
module operand_fetch_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    operand_fetch_stage_if.slave   bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [ADDR_WIDTH-1:0] src_idx  [2];
    logic [DATA_WIDTH-1:0] src_rf   [2];
    logic [DATA_WIDTH-1:0] operand  [2];
    logic [1:0]            src_matches_ex;

    logic load_use;
    logic in_ready;
    logic accept;

    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] op_a_reg;
    logic [DATA_WIDTH-1:0] op_b_reg;
    logic [ADDR_WIDTH-1:0] rd_reg;
    logic                  reg_write_reg;
    logic                  is_load_reg;
    logic [CNT_WIDTH-1:0]  stall_count_reg;

    assign src_idx[0] = bus.in_rs1;
    assign src_idx[1] = bus.in_rs2;
    assign src_rf[0]  = bus.rf_dataA;
    assign src_rf[1]  = bus.rf_dataB;

    assign bus.rf_addrA = bus.in_rs1;
    assign bus.rf_addrB = bus.in_rs2;

    // Bypass priority: x0, then EX (youngest), then WB (write the file has not shown yet), then file.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic src_zero;
            logic ex_hit;
            logic wb_hit;

            assign src_zero = (src_idx[gi] == '0);
            assign ex_hit   = bus.ex_reg_write && !bus.ex_is_load && (bus.ex_rd == src_idx[gi]);
            assign wb_hit   = bus.wb_reg_write && (bus.wb_rd == src_idx[gi]);

            assign operand[gi] = src_zero ? '0          :
                                 ex_hit   ? bus.ex_result :
                                 wb_hit   ? bus.wb_data   :
                                            src_rf[gi];

            assign src_matches_ex[gi] = (bus.ex_rd == src_idx[gi]);
        end
    endgenerate

    // Both sources are checked even if the instruction does not use one of them.
    assign load_use = bus.in_valid && bus.ex_reg_write && bus.ex_is_load &&
                      (bus.ex_rd != '0) && (|src_matches_ex);

    assign in_ready = !bus.flush && !load_use && (!out_valid_reg || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_reg <= 1'b0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
            is_load_reg   <= 1'b0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            op_a_reg      <= operand[0];
            op_b_reg      <= operand[1];
            rd_reg        <= bus.in_rd;
            reg_write_reg <= bus.in_reg_write;
            is_load_reg   <= bus.in_is_load;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_count_reg <= '0;
        end else if (load_use && !bus.flush && (stall_count_reg != CNT_MAX)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_reg;
    assign bus.out_opA       = op_a_reg;
    assign bus.out_opB       = op_b_reg;
    assign bus.out_rd        = rd_reg;
    assign bus.out_reg_write = reg_write_reg;
    assign bus.out_is_load   = is_load_reg;
    assign bus.stall_count   = stall_count_reg;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Randomized bench for operand_fetch_stage against an architectural-level model,
// plus directed scenarios with hand-computed expectations.
module tb_operand_fetch_stage;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int CW = 16;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    operand_fetch_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) b ();

    operand_fetch_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (b)
    );

    // Register file: posedge write, asynchronous read.
    logic [DW-1:0] rf [32] = '{default: '0};
    assign b.rf_dataA = rf[b.rf_addrA];
    assign b.rf_dataB = rf[b.rf_addrB];
    always @(posedge Clk) if (b.wb_reg_write) rf[b.wb_rd] <= b.wb_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value an instruction must see for source rs: newest producer wins, x0 is zero.
    function automatic logic [DW-1:0] m_operand(input logic [AW-1:0] rs);
        if (rs == 0) return '0;
        if (b.ex_reg_write && !b.ex_is_load && b.ex_rd == rs) return b.ex_result;
        if (b.wb_reg_write && b.wb_rd == rs) return b.wb_data;
        return rf[rs];
    endfunction

    function automatic bit m_load_use();
        return b.in_valid && b.ex_reg_write && b.ex_is_load && b.ex_rd != 0 &&
               (b.ex_rd == b.in_rs1 || b.ex_rd == b.in_rs2);
    endfunction

    bit            m_valid;
    logic [DW-1:0] m_opA, m_opB;
    logic [AW-1:0] m_rd;
    bit            m_rw, m_ld;
    int            m_stalls;

    function automatic bit m_in_ready();
        return !b.flush && !m_load_use() && (!m_valid || b.out_ready);
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_valid = 0; m_opA = '0; m_opB = '0; m_rd = '0; m_rw = 0; m_ld = 0; m_stalls = 0;
        end else begin
            bit lu, take;
            lu   = m_load_use();
            take = b.in_valid && m_in_ready();
            if (b.flush) m_valid = 0;
            else if (take) begin
                m_valid = 1;
                m_opA = m_operand(b.in_rs1);
                m_opB = m_operand(b.in_rs2);
                m_rd = b.in_rd; m_rw = b.in_reg_write; m_ld = b.in_is_load;
            end else if (b.out_ready) m_valid = 0;
            if (lu && !b.flush && m_stalls < (1 << CW) - 1) m_stalls++;
        end
    end

    always @(negedge Clk) begin
        if (Rst_n && cmp_en) begin
            check("in_ready",      b.in_ready,      m_in_ready());
            check("rf_addrA",      b.rf_addrA,      b.in_rs1);
            check("rf_addrB",      b.rf_addrB,      b.in_rs2);
            check("out_valid",     b.out_valid,     m_valid);
            check("out_opA",       b.out_opA,       m_opA);
            check("out_opB",       b.out_opB,       m_opB);
            check("out_rd",        b.out_rd,        m_rd);
            check("out_reg_write", b.out_reg_write, m_rw);
            check("out_is_load",   b.out_is_load,   m_ld);
            check("stall_count",   b.stall_count,   m_stalls[CW-1:0]);
        end
    end

    task automatic set_idle();
        b.flush = 0; b.in_valid = 0; b.in_rs1 = '0; b.in_rs2 = '0; b.in_rd = '0;
        b.in_reg_write = 0; b.in_is_load = 0;
        b.ex_rd = '0; b.ex_reg_write = 0; b.ex_is_load = 0; b.ex_result = '0;
        b.wb_rd = '0; b.wb_reg_write = 0; b.wb_data = '0; b.out_ready = 1;
    endtask

    task automatic cycle();
        @(posedge Clk);
        #2;
    endtask

    task automatic randomize_inputs();
        b.flush        = ($urandom_range(0, 15) == 0);
        b.in_valid     = ($urandom_range(0, 3) != 0);
        b.in_rs1       = AW'($urandom_range(0, 7));
        b.in_rs2       = AW'($urandom_range(0, 7));
        b.in_rd        = AW'($urandom_range(0, 31));
        b.in_reg_write = $urandom_range(0, 1) == 1;
        b.in_is_load   = $urandom_range(0, 1) == 1;
        b.ex_rd        = AW'($urandom_range(0, 7));
        b.ex_reg_write = ($urandom_range(0, 3) != 0);
        b.ex_is_load   = ($urandom_range(0, 3) == 0);
        b.ex_result    = {$urandom, $urandom};
        b.wb_rd        = AW'($urandom_range(0, 7));
        b.wb_reg_write = ($urandom_range(0, 2) != 0);
        b.wb_data      = {$urandom, $urandom};
        b.out_ready    = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        set_idle();
        repeat (3) @(posedge Clk);
        #1;
        check("reset_out_valid", b.out_valid, 1'b0);
        check("reset_stall_count", b.stall_count, '0);
        #1;
        Rst_n = 1'b1;
        cmp_en = 1'b1;

        // Load x3 and x4 through the write port.
        b.wb_reg_write = 1; b.wb_rd = 5'd3; b.wb_data = 64'h11; cycle();
        b.wb_rd = 5'd4; b.wb_data = 64'h22; cycle();
        b.wb_reg_write = 0;

        // Plain file read.
        b.in_valid = 1; b.in_rs1 = 5'd3; b.in_rs2 = 5'd4; cycle();
        check("t2_valid", b.out_valid, 1'b1);
        check("t2_opA", b.out_opA, 64'h11);
        check("t2_opB", b.out_opB, 64'h22);

        // EX beats WB on the same source; then WB alone.
        b.in_rs1 = 5'd5; b.in_rs2 = 5'd0;
        b.ex_reg_write = 1; b.ex_rd = 5'd5; b.ex_result = 64'hAA;
        b.wb_reg_write = 1; b.wb_rd = 5'd5; b.wb_data = 64'hBB;
        cycle();
        check("t3_ex_wins", b.out_opA, 64'hAA);
        b.ex_reg_write = 0;
        cycle();
        check("t3_wb_fwd", b.out_opA, 64'hBB);
        b.wb_reg_write = 0;

        // x0 never forwards.
        b.in_rs1 = 5'd0; b.ex_reg_write = 1; b.ex_rd = 5'd0; b.ex_result = 64'hFF;
        cycle();
        check("t5_x0", b.out_opA, 64'h0);

        // Load-use on rs2: one bubble, then WB supplies the loaded value.
        b.ex_is_load = 1; b.ex_rd = 5'd7; b.in_rs2 = 5'd7; b.in_rd = 5'd9;
        #1;
        check("t4_in_ready_stall", b.in_ready, 1'b0);
        #1;
        cycle();
        check("t4_bubble", b.out_valid, 1'b0);
        check("t4_stall_count", b.stall_count, 16'd1);
        b.ex_reg_write = 0; b.ex_is_load = 0;
        b.wb_reg_write = 1; b.wb_rd = 5'd7; b.wb_data = 64'h5;
        #1;
        check("t4_in_ready_retry", b.in_ready, 1'b1);
        #1;
        cycle();
        check("t4_retry_valid", b.out_valid, 1'b1);
        check("t4_retry_opB", b.out_opB, 64'h5);
        b.wb_reg_write = 0;

        // Backpressure holds everything; flush then kills the entry.
        b.in_rs1 = 5'd3; b.in_rs2 = 5'd4; b.in_rd = 5'd1; b.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_in_ready_hold", b.in_ready, 1'b0);
            #1;
            cycle();
            check("t6_valid_hold", b.out_valid, 1'b1);
            check("t6_opB_hold", b.out_opB, 64'h5);
            check("t6_rd_hold", b.out_rd, 5'd9);
        end
        b.flush = 1;
        #1;
        check("t6_in_ready_flush", b.in_ready, 1'b0);
        #1;
        cycle();
        check("t6_flush_kill", b.out_valid, 1'b0);
        set_idle();
        cycle();

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            cycle();
        end

        // Asynchronous reset in the middle of traffic.
        randomize_inputs();
        #1;
        Rst_n = 1'b0;
        #1;
        check("t1_valid", b.out_valid, 1'b0);
        check("t1_opA", b.out_opA, '0);
        check("t1_opB", b.out_opB, '0);
        check("t1_stall_count", b.stall_count, '0);
        cycle();
        Rst_n = 1'b1;

        for (int i = 0; i < 500; i++) begin
            randomize_inputs();
            cycle();
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
